// File: rtl/divider_8by4_seq.sv
// Sequential 8-by-4 unsigned restoring divider.
// Produces one quotient bit per cycle, MSB first, and flags divide-by-zero.
module divider_8by4_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  localparam int unsigned DVD_W = 8;
  localparam int unsigned DVS_W = 4;
  localparam int unsigned PAR_W = DVS_W + 1;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned ITERS = DVD_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic               zero_pend;
  logic [DVD_W-1:0]   dvd;
  logic [DVS_W-1:0]   dvs;
  logic [DVS_W-1:0]   rem_q;
  logic [DVD_W-1:0]   quo;
  logic [CNT_W-1:0]   cnt;

  logic [PAR_W-1:0]   shifted;
  logic [DVS_W-1:0]   next_rem;
  logic               q_bit;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted  = {rem_q, dvd[DVD_W-1]};
    q_bit    = 1'b0;
    next_rem = shifted[DVS_W-1:0];
    if (shifted >= {1'b0, dvs}) begin
      q_bit    = 1'b1;
      next_rem = DVS_W'(shifted - {1'b0, dvs});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      zero_pend   <= 1'b0;
      dvd         <= '0;
      dvs         <= '0;
      rem_q       <= '0;
      quo         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // A zero-divisor operation spends one extra IDLE cycle before DONE.
          if (zero_pend) begin
            zero_pend   <= 1'b0;
            state       <= S_DONE;
            done        <= 1'b1;
            quotient    <= '1;
            remainder   <= dvd[DVS_W-1:0];
            div_by_zero <= 1'b1;
          end else if (start) begin
            dvd         <= dividend;
            dvs         <= divisor;
            rem_q       <= '0;
            quo         <= '0;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            if (divisor != '0) begin
              state <= S_BUSY;
              busy  <= 1'b1;
            end else begin
              zero_pend <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          dvd   <= {dvd[DVD_W-2:0], 1'b0};
          rem_q <= next_rem;
          quo   <= {quo[DVD_W-2:0], q_bit};
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITERS - 1)) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= {quo[DVD_W-2:0], q_bit};
            remainder <= next_rem;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
